// File: rtl/control_unit_pkg.sv
// Shared state, opcode and ALU encodings for the control unit and its sub-blocks.
// Constants only: no logic, no latency, no flow control.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/control_unit_instruc_reg.sv
// Instruction register: loads the ROM word when ld_i is high, otherwise holds.
// Zero latency beyond the load edge; cleared asynchronously by reset.
module instruc_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] ir_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     ir_q <= 16'h0000;
    else if (ld_i) ir_q <= d_i;
  end

  assign q_o = ir_q;

endmodule

// File: rtl/control_unit_instruction_mem.sv
// 128x16 program ROM with a registered read port, one cycle of latency.
// No reset on the output register and no stall: it samples the address every clock.
module instruction_mem (
  input  logic        clk_i,
  input  logic [6:0]  addr_i,
  output logic [15:0] data_o
);

  logic [15:0] data_q;

  function automatic logic [15:0] rom_word(input logic [6:0] a);
    case (a)
      7'd0:    rom_word = 16'h20B1;
      7'd1:    rom_word = 16'h21B2;
      7'd2:    rom_word = 16'h2063;
      7'd3:    rom_word = 16'h28A4;
      7'd4:    rom_word = 16'h4145;
      7'd5:    rom_word = 16'h4326;
      7'd6:    rom_word = 16'h3560;
      7'd7:    rom_word = 16'h1CD0;
      7'd8:    rom_word = 16'h5000;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    data_q <= rom_word(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/control_unit_pc_counter.sv
// 7-bit program counter: clear beats increment, 127 rolls over to 0.
// Updates on the clock edge; cleared asynchronously by reset.
module pc_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       up_i,
  output logic [6:0] pc_o
);

  logic [6:0] pc_q;
  logic [6:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr_i)     pc_d = 7'd0;
    else if (up_i) pc_d = pc_q + 7'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= 7'd0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/control_unit_state_machine.sv
// Fetch/decode/execute sequencer; all datapath controls are Moore outputs of the state.
// Decodes from the instruction register, never from the raw ROM word.
module state_machine
  import control_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] ir_i,
  output logic [3:0]  state_o,
  output logic [3:0]  next_state_o,
  output logic [7:0]  d_addr_o,
  output logic        d_wr_o,
  output logic        rf_s_o,
  output logic        rf_w_en_o,
  output logic [3:0]  rf_ra_addr_o,
  output logic [3:0]  rf_rb_addr_o,
  output logic [3:0]  rf_w_addr_o,
  output logic [2:0]  alu_s0_o,
  output logic        pc_clr_o,
  output logic        pc_up_o,
  output logic        ir_ld_o
);

  state_e state_q;
  state_e state_d;

  always_comb begin
    state_d      = state_q;
    d_addr_o     = 8'h00;
    d_wr_o       = 1'b0;
    rf_s_o       = 1'b0;
    rf_w_en_o    = 1'b0;
    rf_ra_addr_o = 4'h0;
    rf_rb_addr_o = 4'h0;
    rf_w_addr_o  = 4'h0;
    alu_s0_o     = ALU_PASS;
    pc_clr_o     = 1'b0;
    pc_up_o      = 1'b0;
    ir_ld_o      = 1'b0;
    case (state_q)
      S_INIT: begin
        pc_clr_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        ir_ld_o = 1'b1;
        pc_up_o = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_i[15:12])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOADA;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP: state_d = S_FETCH;
      // LoadA settles the memory address; LoadB repeats it and commits the write.
      S_LOADA, S_LOADB: begin
        d_addr_o    = ir_i[11:4];
        rf_s_o      = 1'b1;
        rf_w_addr_o = ir_i[3:0];
        rf_w_en_o   = (state_q == S_LOADB);
        state_d     = (state_q == S_LOADA) ? S_LOADB : S_FETCH;
      end
      S_STORE: begin
        d_addr_o     = ir_i[11:4];
        rf_ra_addr_o = ir_i[3:0];
        d_wr_o       = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr_o = ir_i[11:8];
        rf_rb_addr_o = ir_i[7:4];
        rf_w_addr_o  = ir_i[3:0];
        rf_w_en_o    = 1'b1;
        alu_s0_o     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        state_d      = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  assign state_o      = state_q;
  assign next_state_o = state_d;

endmodule

// File: rtl/control_unit.sv
// Top level of the multi-cycle control unit: ROM, IR, PC and sequencer wired together.
// Instruction fetch has one cycle of ROM latency; there is no external stall input.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        reset,
  input  logic        clk,
  output logic [3:0]  OutState,
  output logic [3:0]  NextState,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [3:0]  RF_W_addr,
  output logic [2:0]  ALU_s0,
  output logic [6:0]  PC_Out,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [15:0] IR_Out,
  output logic [15:0] data
);

  instruction_mem u_imem (
    .clk_i  (clk),
    .addr_i (PC_Out),
    .data_o (data)
  );

  instruc_reg u_ir (
    .clk_i (clk),
    .rst_i (reset),
    .ld_i  (IR_ld),
    .d_i   (data),
    .q_o   (IR_Out)
  );

  pc_counter u_pc (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (PC_clr),
    .up_i  (PC_up),
    .pc_o  (PC_Out)
  );

  state_machine u_fsm (
    .clk_i        (clk),
    .rst_i        (reset),
    .ir_i         (IR_Out),
    .state_o      (OutState),
    .next_state_o (NextState),
    .d_addr_o     (D_addr),
    .d_wr_o       (D_wr),
    .rf_s_o       (RF_s),
    .rf_w_en_o    (RF_W_en),
    .rf_ra_addr_o (RF_Ra_addr),
    .rf_rb_addr_o (RF_Rb_addr),
    .rf_w_addr_o  (RF_W_addr),
    .alu_s0_o     (ALU_s0),
    .pc_clr_o     (PC_clr),
    .pc_up_o      (PC_up),
    .ir_ld_o      (IR_ld)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks the built-in program, HALT, and async resets.
// Expected values are hand-derived from the ROM contents and state table.
module tb_control_unit;

  logic        reset;
  logic        clk;
  logic [3:0]  OutState, NextState;
  logic [7:0]  D_addr;
  logic        D_wr, RF_s, RF_W_en;
  logic [3:0]  RF_Ra_addr, RF_Rb_addr, RF_W_addr;
  logic [2:0]  ALU_s0;
  logic [6:0]  PC_Out;
  logic        PC_clr, PC_up, IR_ld;
  logic [15:0] IR_Out, data;

  int vectors = 0;
  int miscompares = 0;

  control_unit dut (
    .reset      (reset),
    .clk        (clk),
    .OutState   (OutState),
    .NextState  (NextState),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .RF_W_addr  (RF_W_addr),
    .ALU_s0     (ALU_s0),
    .PC_Out     (PC_Out),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .IR_Out     (IR_Out),
    .data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    for (int i = 0; i < budget && OutState !== s; i++) step();
    chk("wait_state", {28'd0, OutState}, {28'd0, s});
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", OutState, 4'd0);
    chk("rst_pc",    PC_Out,   7'd0);
    chk("rst_ir",    IR_Out,   16'h0000);

    @(negedge clk) reset = 1'b0;
    #1;
    chk("init_state", OutState,  4'd0);
    chk("init_next",  NextState, 4'd1);
    chk("init_clr",   PC_clr,    1'b1);

    step();
    chk("fetch_state", OutState, 4'd1);
    chk("fetch_data",  data,     16'h20B1);
    chk("fetch_pc",    PC_Out,   7'd0);
    chk("fetch_ctl",   {IR_ld, PC_up, PC_clr}, 3'b110);

    step();
    chk("dec_state", OutState,  4'd2);
    chk("dec_ir",    IR_Out,    16'h20B1);
    chk("dec_pc",    PC_Out,    7'd1);
    chk("dec_next",  NextState, 4'd4);

    step();
    chk("loada_state", OutState, 4'd4);
    chk("loada_ctl", {D_addr, RF_W_addr, RF_s, RF_W_en, D_wr}, {8'h0B, 4'd1, 3'b100});

    step();
    chk("loadb_state", OutState, 4'd5);
    chk("loadb_ctl", {D_addr, RF_W_addr, RF_s, RF_W_en, D_wr}, {8'h0B, 4'd1, 3'b110});

    wait_state(4'd8, 40);
    chk("sub_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {4'd1, 4'd4, 4'd5});
    chk("sub_ctl",  {ALU_s0, RF_W_en, RF_s, D_wr}, {3'b010, 3'b100});

    step();
    wait_state(4'd7, 20);
    chk("add_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {4'd5, 4'd6, 4'd0});
    chk("add_ctl",  {ALU_s0, RF_W_en, RF_s, D_wr}, {3'b001, 3'b100});

    wait_state(4'd6, 20);
    chk("store_ctl", {D_addr, RF_Ra_addr, D_wr, RF_W_en}, {8'hCD, 4'd0, 2'b10});

    wait_state(4'd9, 20);
    for (int i = 0; i < 3; i++) begin
      chk("halt_state", OutState, 4'd9);
      chk("halt_pc",    PC_Out,   7'd9);
      chk("halt_en", {D_wr, RF_W_en, PC_up, PC_clr, IR_ld, ALU_s0}, 8'd0);
      step();
    end

    reset = 1'b1;
    #1;
    chk("halt_rst_state", OutState, 4'd0);
    chk("halt_rst_pc",    PC_Out,   7'd0);
    @(negedge clk) reset = 1'b0;

    wait_state(4'd7, 60);
    chk("add2_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {4'd5, 4'd6, 4'd0});
    #2 reset = 1'b1;
    #1;
    chk("add_rst_state", OutState, 4'd0);
    chk("add_rst_pc",    PC_Out,   7'd0);
    chk("add_rst_ir",    IR_Out,   16'h0000);
    @(negedge clk) reset = 1'b0;

    step();
    chk("re_fetch_state", OutState, 4'd1);
    chk("re_fetch_data",  data,     16'h20B1);
    step();
    chk("re_dec_ir", IR_Out, 16'h20B1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; program, widths and encodings are fixed.
REQ-002 clk  in  1  single system clock; all registers update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; positional port order is reset, clk, then the outputs below.
REQ-004 OutState  out  4  current state code.
REQ-005 NextState  out  4  combinational next-state code.
REQ-006 D_addr  out  8  data-memory address.
REQ-007 D_wr  out  1  data-memory write enable.
REQ-008 RF_s  out  1  register-file write-data mux select (1 = data memory, 0 = ALU).
REQ-009 RF_W_en  out  1  register-file write enable.
REQ-010 RF_Ra_addr, RF_Rb_addr, RF_W_addr  out  4 each  register-file read A, read B and write addresses.
REQ-011 ALU_s0  out  3  ALU op: 000 pass, 001 add, 010 sub.
REQ-012 PC_Out  out  7  program counter and instruction-memory address.
REQ-013 PC_clr, PC_up, IR_ld  out  1 each  PC clear, PC increment, IR load.
REQ-014 IR_Out  out  16  instruction register; data  out  16  instruction-memory read data.

Function
REQ-015 Instruction memory: 128x16 ROM with registered output, data <= rom[PC_Out] every clock, one-cycle latency.
REQ-016 ROM addresses 0-8 hold 20B1, 21B2, 2063, 28A4, 4145, 4326, 3560, 1CD0, 5000 (hex); all other addresses hold 0000.
REQ-017 IR: IR_Out <= data when IR_ld = 1; otherwise it holds its value.
REQ-018 PC: PC_clr forces 0 with priority over PC_up; PC_up increments by 1; 127 wraps to 0.
REQ-019 Opcode IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT; codes 6-F execute as NOOP.
REQ-020 Fields: LOAD/STORE D_addr = IR[11:4], reg = IR[3:0]; ADD/SUB Ra = IR[11:8], Rb = IR[7:4], W = IR[3:0].
REQ-021 State codes: Init 0, Fetch 1, Decode 2, Noop 3, LoadA 4, LoadB 5, Store 6, Add 7, Sub 8, Halt 9.
REQ-022 Transitions: Init->Fetch; Fetch->Decode; Decode->opcode state; LoadA->LoadB; Noop/LoadB/Store/Add/Sub->Fetch; Halt->Halt until reset.
REQ-023 Outputs default to 0 in every state; only the assertions below differ.
REQ-024 Init: PC_clr = 1. Fetch: IR_ld = 1 and PC_up = 1. Decode, Noop and Halt: defaults only.
REQ-025 LoadA: D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0]. LoadB: the same outputs plus RF_W_en = 1.
REQ-026 Store: D_addr = IR[11:4], RF_Ra_addr = IR[3:0], D_wr = 1.
REQ-027 Add/Sub: Ra, Rb and W taken from the fields; RF_W_en = 1; RF_s = 0; ALU_s0 = 001 for Add, 010 for Sub.
REQ-028 Decode is taken from IR_Out, not from data.
REQ-029 Because each instruction spends at least one cycle in Decode with PC stable, Fetch always sees data = rom[PC_Out].

Reset
REQ-030 While reset is high: state = Init, PC_Out = 0 and IR_Out = 0, all applied asynchronously.
REQ-031 The ROM output register is not reset; during Init it captures rom[0].
REQ-032 Reset asserted mid-instruction, including in Halt, aborts the instruction and returns to Init.

Structure
REQ-033 Package control_unit_pkg holds the state enum, the opcode constants and the ALU_s0 codes.
REQ-034 Sub-modules: instruction_mem, instruc_reg, pc_counter and state_machine; state_machine is the main one, and the top level only wires them together.

Verification
REQ-035 Reset for 2 cycles, then release -> OutState 0, then 1; at the first Fetch, data = 20B1 and PC_Out = 0.
REQ-036 First LOAD -> in LoadB: D_addr = 0x0B, RF_W_addr = 1, RF_s = 1, RF_W_en = 1, D_wr = 0.
REQ-037 First SUB -> in state 8: Ra = 1, Rb = 4, W = 5, ALU_s0 = 010, RF_W_en = 1; the ADD that follows gives Ra = 5, Rb = 6, W = 0, ALU_s0 = 001.
REQ-038 STORE -> in state 6: D_addr = 0xCD, RF_Ra_addr = 0, D_wr = 1, RF_W_en = 0.
REQ-039 HALT -> OutState = 9 and PC_Out = 9, both holding for 3 or more cycles with all enables at 0.
REQ-040 Reset pulse while in state 7 -> OutState 0 and PC_Out 0 immediately, and the program restarts at 20B1.
